idea_round_sequencer: RTL and testbench

Iterative IDEA encryption controller that time-shares a single instance of the team's `round` unit across all 8 rounds, then applies the output transform with two `inmultire` instances. It accepts one 64-bit block and one 128-bit key per transaction over a valid/ready handshake. It generates the 52 subkeys serially from a rotating key register and returns the ciphertext over a second valid/ready handshake. It replaces the fully unrolled encoder where area matters more than throughput.

---
 rtl/idea_round_sequencer_if.sv | 21 ++
 rtl/idea_round_sequencer.sv | 170 +++++++++++++++++
 tb/tb_idea_round_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idea_round_sequencer_if.sv
// Handshake bundle for idea_round_sequencer: block/key input channel and
// ciphertext output channel, each with its own valid/ready pair.
interface idea_round_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] k;
    logic [63:0]  x;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  x_out;

    modport master (
        output in_valid, k, x, out_ready,
        input  in_ready, out_valid, x_out
    );

    modport slave (
        input  in_valid, k, x, out_ready,
        output in_ready, out_valid, x_out
    );
endinterface

// File: rtl/idea_round_sequencer.sv
// Iterative IDEA encryptor: one shared round unit, subkeys generated serially
// from a rotating key register, output transform after round 8.
// Optional feature macro: IDEA_ABORT_EN adds an ABORT input that returns the
// sequencer to IDLE from any busy state.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// KEY   | emitting 6 round subkeys into the buffer
// RND   | one IDEA round applied to the state register
// FKEY  | emitting the 4 output-transform subkeys
// FIN   | output transform registered into x_out
// DONE  | out_valid high until out_ready

// Multiplication mod 65537 with 0 standing for 65536.
module inmultire (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] p
);
    logic [31:0] prod;
    logic [15:0] lo, hi;

    assign prod = a * b;
    assign lo   = prod[15:0];
    assign hi   = prod[31:16];

    // 2^16 = -1 mod 65537, so a*b = lo - hi (plus one when it borrows)
    always_comb begin
        if (a == 16'd0)
            p = 16'd1 - b;
        else if (b == 16'd0)
            p = 16'd1 - a;
        else
            p = lo - hi + {15'd0, (lo < hi)};
    end
endmodule

// One full IDEA round; output already has the middle words exchanged.
module round (
    input  logic [63:0] x,
    input  logic [15:0] z1, z2, z3, z4, z5, z6,
    output logic [63:0] y
);
    logic [15:0] a, b, c, d, e, f, g, h, i, j;

    inmultire u_m1 (.a(x[63:48]), .b(z1), .p(a));
    inmultire u_m4 (.a(x[15:0]),  .b(z4), .p(d));
    inmultire u_m5 (.a(e),        .b(z5), .p(g));
    inmultire u_m6 (.a(h),        .b(z6), .p(i));

    assign b = x[47:32] + z2;
    assign c = x[31:16] + z3;
    assign e = a ^ c;
    assign f = b ^ d;
    assign h = f + g;
    assign j = g + i;
    assign y = {a ^ i, c ^ i, b ^ j, d ^ j};
endmodule

module idea_round_sequencer (
    input  logic clk,
    input  logic rst_n,
`ifdef IDEA_ABORT_EN
    input  logic abort,
`endif
    idea_round_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, KEY, RND, FKEY, FIN, DONE} state_t;

    state_t       state, state_nx;
    logic [63:0]  xr;
    logic [127:0] kr;
    logic [2:0]   sk, c, r;
    logic [15:0]  zb [0:5];
    logic [63:0]  x_out_q;
    logic [63:0]  rnd_out, fin_out;
    logic [15:0]  fin_w1, fin_w4;
    logic         abort_hit;

`ifdef IDEA_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    round u_round (
        .x(xr), .z1(zb[0]), .z2(zb[1]), .z3(zb[2]),
        .z4(zb[3]), .z5(zb[4]), .z6(zb[5]), .y(rnd_out)
    );

    inmultire u_fin1 (.a(xr[63:48]), .b(zb[0]), .p(fin_w1));
    inmultire u_fin4 (.a(xr[15:0]),  .b(zb[3]), .p(fin_w4));

    assign fin_out = {fin_w1, xr[47:32] + zb[1], xr[31:16] + zb[2], fin_w4};

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.x_out     = x_out_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic; abort overrides everything outside IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid)    state_nx = KEY;
            KEY:     if (sk == 3'd5)      state_nx = RND;
            RND:     state_nx = (r == 3'd7) ? FKEY : KEY;
            FKEY:    if (sk == 3'd3)      state_nx = FIN;
            FIN:     state_nx = DONE;
            DONE:    if (bus.out_ready)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort_hit)
            state_nx = IDLE;
    end

    // Datapath: block/key load, serial subkey generation, rounds, output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr      <= '0;
            kr      <= '0;
            sk      <= '0;
            c       <= '0;
            r       <= '0;
            x_out_q <= '0;
            for (int n = 0; n < 6; n++)
                zb[n] <= '0;
        end else if (!abort_hit) begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        xr <= bus.x;
                        kr <= bus.k;
                        sk <= '0;
                        c  <= '0;
                        r  <= '0;
                    end
                end
                KEY, FKEY: begin
                    zb[sk] <= kr[127:112];
                    // eighth step adds the extra 25 so the schedule advances
                    // by 25 bits per group of eight subkeys
                    kr <= (c == 3'd7) ? {kr[86:0], kr[127:87]}
                                      : {kr[111:0], kr[127:112]};
                    c  <= c + 3'd1;
                    if ((state == KEY && sk == 3'd5) || (state == FKEY && sk == 3'd3))
                        sk <= '0;
                    else
                        sk <= sk + 3'd1;
                end
                RND: begin
                    // last round undoes the middle-word exchange
                    xr <= (r == 3'd7) ? {rnd_out[63:48], rnd_out[31:16],
                                         rnd_out[47:32], rnd_out[15:0]}
                                      : rnd_out;
                    r  <= r + 3'd1;
                end
                FIN:     x_out_q <= fin_out;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_idea_round_sequencer.sv
// Bench for idea_round_sequencer: vector table, corner-case sequences and
// randomized blocks compared against a textbook IDEA model.
module tb_idea_round_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef IDEA_ABORT_EN
    logic abort = 1'b0;
`endif
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;

    localparam logic [127:0] K_STD = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
    localparam logic [63:0]  X_STD = 64'h0000_0001_0002_0003;
    localparam logic [63:0]  Y_STD = 64'h11FB_ED2B_0198_6DE5;

    idea_round_sequencer_if bus ();

    idea_round_sequencer dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef IDEA_ABORT_EN
        .abort(abort),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [15:0] mm(input logic [15:0] a, input logic [15:0] b);
        longint aa, bb, p;
        aa = (a == 16'd0) ? 65536 : longint'(a);
        bb = (b == 16'd0) ? 65536 : longint'(b);
        p  = (aa * bb) % 65537;
        return (p == 65536) ? 16'd0 : 16'(p);
    endfunction

    function automatic logic [15:0] subkey(input logic [127:0] key, input int idx);
        logic [127:0] t, s;
        t = key;
        for (int j = 0; j < idx / 8; j++)
            t = {t[102:0], t[127:103]};
        s = t << (16 * (idx % 8));
        return s[127:112];
    endfunction

    function automatic logic [63:0] idea_ref(input logic [127:0] key, input logic [63:0] blk);
        logic [15:0] x1, x2, x3, x4, a, b, c, d, e, f, g, h, i, j, t;
        logic [15:0] z [52];
        for (int n = 0; n < 52; n++)
            z[n] = subkey(key, n);
        x1 = blk[63:48]; x2 = blk[47:32]; x3 = blk[31:16]; x4 = blk[15:0];
        for (int rd = 0; rd < 8; rd++) begin
            a = mm(x1, z[6*rd]);
            b = x2 + z[6*rd+1];
            c = x3 + z[6*rd+2];
            d = mm(x4, z[6*rd+3]);
            e = a ^ c;
            f = b ^ d;
            g = mm(e, z[6*rd+4]);
            h = f + g;
            i = mm(h, z[6*rd+5]);
            j = g + i;
            x1 = a ^ i; x4 = d ^ j;
            x2 = b ^ j; x3 = c ^ i;
            if (rd != 7) begin
                t = x2; x2 = x3; x3 = t;
            end
        end
        return {mm(x1, z[48]), 16'(x2 + z[49]), 16'(x3 + z[50]), mm(x4, z[51])};
    endfunction

    // ---------------- check helpers ----------------
    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Accept one block; c0 is the cycle index of the accept edge.
    task automatic accept(input logic [127:0] kk, input logic [63:0] xx, output int c0);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check1("in_ready_before_accept", bus.in_ready, 1'b1);
        bus.k = kk;
        bus.x = xx;
        bus.in_valid = 1'b1;
        @(negedge clk);
        c0 = cyc;
        bus.in_valid = 1'b0;
        check1("in_ready_low_after_accept", bus.in_ready, 1'b0);
    endtask

    task automatic wait_out(input int c0, output int lat);
        int n;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        lat = cyc - c0;
    endtask

    task automatic handshake(input logic [63:0] held);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check1("in_ready_after_handshake", bus.in_ready, 1'b1);
        check1("out_valid_after_handshake", bus.out_valid, 1'b0);
        check64("x_out_held_after_handshake", bus.x_out, held);
    endtask

    task automatic run_one(input string name, input logic [127:0] kk, input logic [63:0] xx,
                           input logic [63:0] exp, input int delay);
        int c0, lat;
        accept(kk, xx, c0);
        wait_out(c0, lat);
        check_int({name, "_latency"}, lat, 61);
        repeat (delay) @(negedge clk);
        check64({name, "_x_out"}, bus.x_out, exp);
        handshake(exp);
    endtask

    typedef struct {
        logic [127:0] k;
        logic [63:0]  x;
        logic [63:0]  exp;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int c0, lat, n, nacc, nout;
        int acc_cyc [2];
        logic [63:0] outs [2];
        logic [127:0] k1, k2, kr;
        logic [63:0] x1, x2, xr, held;

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.k = '0;
        bus.x = '0;

        tbl[0] = '{K_STD, X_STD, Y_STD};
        tbl[1] = '{128'h0, 64'h0, idea_ref(128'h0, 64'h0)};
        kr = {$urandom, $urandom, $urandom, $urandom};
        xr = {$urandom, $urandom};
        tbl[2] = '{kr, xr, idea_ref(kr, xr)};
        tbl[3] = '{{128{1'b1}}, {64{1'b1}}, idea_ref({128{1'b1}}, {64{1'b1}})};

        repeat (3) @(negedge clk);
        check1("reset_in_ready", bus.in_ready, 1'b1);
        check1("reset_out_valid", bus.out_valid, 1'b0);
        check64("reset_x_out", bus.x_out, 64'h0);
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++)
            run_one($sformatf("vec%0d", v), tbl[v].k, tbl[v].x, tbl[v].exp, 0);

        // backpressure: result and handshake signals frozen, in_valid ignored
        accept(K_STD, X_STD, c0);
        wait_out(c0, lat);
        check_int("bp_latency", lat, 61);
        for (int t = 0; t < 20; t++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.k = {$urandom, $urandom, $urandom, $urandom};
            bus.x = {$urandom, $urandom};
            @(negedge clk);
            check64("bp_x_out_stable", bus.x_out, Y_STD);
            check1("bp_out_valid_stable", bus.out_valid, 1'b1);
            check1("bp_in_ready_low", bus.in_ready, 1'b0);
        end
        bus.in_valid = 1'b0;
        handshake(Y_STD);

        // back-to-back with out_ready tied high and in_valid held high
        k1 = {$urandom, $urandom, $urandom, $urandom};
        x1 = {$urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        x2 = {$urandom, $urandom};
        bus.out_ready = 1'b1;
        bus.k = k1;
        bus.x = x1;
        bus.in_valid = 1'b1;
        nacc = 0;
        nout = 0;
        n = 0;
        while (nout < 2 && n < 400) begin
            if (nacc == 1) begin
                bus.k = k2;
                bus.x = x2;
            end
            if (nacc == 2)
                bus.in_valid = 1'b0;
            if (bus.in_valid && bus.in_ready && nacc < 2) begin
                acc_cyc[nacc] = cyc + 1;
                nacc++;
            end
            if (bus.out_valid) begin
                outs[nout] = bus.x_out;
                nout++;
            end
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check_int("b2b_outputs_seen", nout, 2);
        check_int("b2b_accepts_seen", nacc, 2);
        if (nacc == 2)
            check_int("b2b_accept_spacing", acc_cyc[1] - acc_cyc[0], 63);
        if (nout == 2) begin
            check64("b2b_result0", outs[0], idea_ref(k1, x1));
            check64("b2b_result1", outs[1], idea_ref(k2, x2));
        end
        @(negedge clk);

        // async reset mid-transaction (x_out currently holds a prior result)
        held = bus.x_out;
        check1("pre_reset_x_out_nonzero", (held != 64'h0), 1'b1);
        accept(K_STD, X_STD, c0);
        repeat (29) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check1("async_reset_in_ready", bus.in_ready, 1'b1);
        check1("async_reset_out_valid", bus.out_valid, 1'b0);
        check64("async_reset_x_out", bus.x_out, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_one("after_reset", K_STD, X_STD, Y_STD, 0);

`ifdef IDEA_ABORT_EN
        accept(k1, x1, c0);
        repeat (19) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check1("abort_in_ready", bus.in_ready, 1'b1);
        check1("abort_out_valid", bus.out_valid, 1'b0);
        check64("abort_x_out_unchanged", bus.x_out, Y_STD);
        run_one("after_abort", K_STD, X_STD, Y_STD, 0);
`endif

        // randomized blocks with random downstream stall
        for (int t = 0; t < 6; t++) begin
            kr = {$urandom, $urandom, $urandom, $urandom};
            xr = {$urandom, $urandom};
            run_one($sformatf("rand%0d", t), kr, xr, idea_ref(kr, xr), int'($urandom_range(0, 5)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1);
    end
endmodule
